// File: rtl/state_src_sel_reg.sv
// Registered source selector for the permutation input.
// Picks one candidate state, applies optional data/key/domain XORs, holds it under valid/ready.
module state_src_sel_reg #(
    parameter int N_SRC      = 3,
    parameter int WORDS      = 5,
    parameter int WORD_W     = 64,
    parameter int RATE_WORDS = 1,
    parameter int KEY_WORDS  = 2,
    parameter int SEL_W      = $clog2(N_SRC)
) (
    input  logic                          clock_i,
    input  logic                          resetb_i,
    input  logic [N_SRC*WORDS*WORD_W-1:0] src_i,
    input  logic [SEL_W-1:0]              sel_i,
    input  logic                          load_i,
    input  logic                          data_xor_en_i,
    input  logic [RATE_WORDS*WORD_W-1:0]  data_i,
    input  logic                          key_xor_en_i,
    input  logic [KEY_WORDS*WORD_W-1:0]   key_i,
    input  logic                          ds_en_i,
    input  logic                          ready_i,
    output logic                          load_ack_o,
    output logic [WORDS*WORD_W-1:0]       state_o,
    output logic                          valid_o,
    output logic                          err_o,
    output logic [15:0]                   stall_cnt_o
);

    localparam int SW = WORDS * WORD_W;
    localparam int KB = (WORDS - KEY_WORDS) * WORD_W;

    typedef enum logic {EMPTY, FULL} fsm_t;

    fsm_t            fsm;
    logic            sel_ok;
    logic            accept;
    logic [SW-1:0]   picked;
    logic [SW-1:0]   nxt;

    assign sel_ok     = 32'(sel_i) < 32'(N_SRC);
    assign accept     = load_i && sel_ok && (fsm == EMPTY || ready_i);
    assign load_ack_o = accept;
    assign valid_o    = (fsm == FULL);

    always_comb begin
        picked = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (sel_i == SEL_W'(k)) picked = src_i[k*SW +: SW];
        end
    end

    always_comb begin
        nxt = picked;
        if (data_xor_en_i)
            nxt[0 +: RATE_WORDS*WORD_W] = nxt[0 +: RATE_WORDS*WORD_W] ^ data_i;
        if (key_xor_en_i)
            nxt[KB +: KEY_WORDS*WORD_W] = nxt[KB +: KEY_WORDS*WORD_W] ^ key_i;
        if (ds_en_i)
            nxt[(WORDS-1)*WORD_W] = ~nxt[(WORDS-1)*WORD_W];
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm         <= EMPTY;
            state_o     <= '0;
            err_o       <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if (load_i && !sel_ok) err_o <= 1'b1;
            // A drained state stays on state_o; only valid_o drops.
            case (fsm)
                EMPTY: begin
                    if (accept) begin
                        fsm         <= FULL;
                        state_o     <= nxt;
                        stall_cnt_o <= '0;
                    end
                end
                FULL: begin
                    if (accept) begin
                        state_o     <= nxt;
                        stall_cnt_o <= '0;
                    end else if (ready_i) begin
                        fsm <= EMPTY;
                    end else if (stall_cnt_o != 16'hFFFF) begin
                        stall_cnt_o <= stall_cnt_o + 16'd1;
                    end
                end
                default: fsm <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_state_src_sel_reg.sv
// Randomised bench for state_src_sel_reg against a word-level reference model.
// A second instance with two rate words checks the wider data injection.
module tb_state_src_sel_reg;

    localparam int N_SRC  = 3;
    localparam int WORDS  = 5;
    localparam int WORD_W = 64;
    localparam int SW     = WORDS * WORD_W;

    logic                   clk = 1'b0;
    logic                   resetb = 1'b0;
    logic [N_SRC*SW-1:0]    src;
    logic [1:0]             sel;
    logic                   load, den, ken, ds, ready;
    logic [63:0]            data1;
    logic [127:0]           data2;
    logic [127:0]           key;

    logic                   ack1, valid1, err1;
    logic [15:0]            stall1;
    logic [SW-1:0]          state1;
    logic                   ack2, valid2, err2;
    logic [15:0]            stall2;
    logic [SW-1:0]          state2;

    logic [63:0]            s [N_SRC][WORDS];
    logic [63:0]            d [2];
    logic [63:0]            k [2];

    logic [SW-1:0]          m1, m2;
    bit                     m_valid, m_err;
    int                     m_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    state_src_sel_reg #(.RATE_WORDS(1)) dut (
        .clock_i(clk), .resetb_i(resetb), .src_i(src), .sel_i(sel),
        .load_i(load), .data_xor_en_i(den), .data_i(data1),
        .key_xor_en_i(ken), .key_i(key), .ds_en_i(ds), .ready_i(ready),
        .load_ack_o(ack1), .state_o(state1), .valid_o(valid1),
        .err_o(err1), .stall_cnt_o(stall1)
    );

    state_src_sel_reg #(.RATE_WORDS(2)) dut2 (
        .clock_i(clk), .resetb_i(resetb), .src_i(src), .sel_i(sel),
        .load_i(load), .data_xor_en_i(den), .data_i(data2),
        .key_xor_en_i(ken), .key_i(key), .ds_en_i(ds), .ready_i(ready),
        .load_ack_o(ack2), .state_o(state2), .valid_o(valid2),
        .err_o(err2), .stall_cnt_o(stall2)
    );

    function automatic logic [SW-1:0] cap(int rate);
        logic [63:0]   v [WORDS];
        logic [SW-1:0] p;
        for (int w = 0; w < WORDS; w++) v[w] = s[sel][w];
        if (den) for (int w = 0; w < rate; w++) v[w] = v[w] ^ d[w];
        if (ken) begin
            v[3] = v[3] ^ k[0];
            v[4] = v[4] ^ k[1];
        end
        if (ds) v[4] = v[4] ^ 64'd1;
        for (int w = 0; w < WORDS; w++) p[w*64 +: 64] = v[w];
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < N_SRC; i++)
            for (int w = 0; w < WORDS; w++)
                src[(i*WORDS+w)*64 +: 64] = s[i][w];
        data1 = d[0];
        data2 = {d[1], d[0]};
        key   = {k[1], k[0]};
    endtask

    task automatic model_clear();
        m1 = '0; m2 = '0;
        m_valid = 0; m_err = 0; m_stall = 0;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < N_SRC; i++)
            for (int w = 0; w < WORDS; w++) s[i][w] = {$urandom, $urandom};
        d[0] = {$urandom, $urandom}; d[1] = {$urandom, $urandom};
        k[0] = {$urandom, $urandom}; k[1] = {$urandom, $urandom};
        sel   = 2'($urandom_range(0, 3));
        load  = ($urandom % 4) != 0;
        ready = ($urandom % 3) != 0;
        den = 1'($urandom); ken = 1'($urandom); ds = 1'($urandom);
    endtask

    // One clock of stimulus with full model comparison.
    task automatic cycle();
        bit acc;
        drive();
        #1;
        acc = load && (sel < 3) && (!m_valid || ready);
        total++;
        if (ack1 !== acc || ack2 !== acc) begin
            bad++;
            $display("FAIL load_ack: got %b/%b want %b", ack1, ack2, acc);
        end
        @(posedge clk);
        if (load && sel >= 3) m_err = 1;
        if (acc) begin
            m1 = cap(1); m2 = cap(2);
            m_valid = 1; m_stall = 0;
        end else if (m_valid && ready) begin
            m_valid = 0;
        end else if (m_valid && m_stall < 65535) begin
            m_stall++;
        end
        #1;
        total++;
        if (state1 !== m1 || state2 !== m2) begin
            bad++;
            $display("FAIL state: got %h want %h (r2 got %h want %h)",
                     state1, m1, state2, m2);
        end
        total++;
        if (valid1 !== m_valid || valid2 !== m_valid) begin
            bad++;
            $display("FAIL valid: got %b want %b", valid1, m_valid);
        end
        total++;
        if (err1 !== m_err) begin
            bad++;
            $display("FAIL err: got %b want %b", err1, m_err);
        end
        total++;
        if (stall1 !== 16'(m_stall)) begin
            bad++;
            $display("FAIL stall_cnt: got %0d want %0d", stall1, m_stall);
        end
    endtask

    task automatic test_reset();
        rand_inputs();
        drive();
        resetb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        total++;
        if (state1 !== '0 || valid1 !== 1'b0 || err1 !== 1'b0 || stall1 !== 16'd0) begin
            bad++;
            $display("FAIL reset: state=%h valid=%b err=%b stall=%0d want all 0",
                     state1, valid1, err1, stall1);
        end
        resetb = 1'b1;
    endtask

    task automatic test_plain_select();
        rand_inputs();
        for (int w = 0; w < WORDS; w++) s[1][w] = 64'h1111_1111_1111_1111;
        sel = 2'd1; load = 1; ready = 1; den = 0; ken = 0; ds = 0;
        cycle();
        total++;
        if (state1 !== {5{64'h1111_1111_1111_1111}} || valid1 !== 1'b1) begin
            bad++;
            $display("FAIL plain_select: state=%h valid=%b want 1111.. valid 1",
                     state1, valid1);
        end
        load = 0;
        cycle();
        total++;
        if (state1 !== {5{64'h1111_1111_1111_1111}} || valid1 !== 1'b0) begin
            bad++;
            $display("FAIL plain_drain: state=%h valid=%b want retained valid 0",
                     state1, valid1);
        end
    endtask

    task automatic test_injection();
        for (int w = 0; w < WORDS; w++) s[0][w] = '0;
        d[0] = 64'hA5A5_A5A5_A5A5_A5A5;
        d[1] = 64'h5A5A_5A5A_5A5A_5A5A;
        k[0] = 64'h0123_4567_89AB_CDEF;
        k[1] = 64'h89AB_CDEF_0123_4567;
        sel = 2'd0; load = 1; ready = 1; den = 1; ken = 1; ds = 1;
        cycle();
        total++;
        if (state1 !== {64'h89AB_CDEF_0123_4566, 64'h0123_4567_89AB_CDEF,
                        64'h0, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5}) begin
            bad++;
            $display("FAIL inject_rate1: got %h", state1);
        end
        total++;
        if (state2 !== {64'h89AB_CDEF_0123_4566, 64'h0123_4567_89AB_CDEF,
                        64'h0, 64'h5A5A_5A5A_5A5A_5A5A, 64'hA5A5_A5A5_A5A5_A5A5}) begin
            bad++;
            $display("FAIL inject_rate2: got %h", state2);
        end
        load = 0; den = 0; ken = 0; ds = 0;
        cycle();
    endtask

    task automatic test_back_pressure();
        rand_inputs();
        sel = 2'd0; load = 1; ready = 1; den = 0; ken = 0; ds = 0;
        cycle();
        for (int i = 0; i < 10; i++) begin
            sel = 2'd2; load = 1; ready = 0;
            den = 1; ken = 1; ds = 1;
            cycle();
        end
        total++;
        if (stall1 !== 16'd10) begin
            bad++;
            $display("FAIL stall_ten: got %0d want 10", stall1);
        end
        sel = 2'd2; load = 1; ready = 1; den = 0; ken = 0; ds = 0;
        cycle();
        total++;
        if (state1 !== src[2*SW +: SW] || stall1 !== 16'd0 || valid1 !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: state=%h stall=%0d valid=%b want src2 0 1",
                     state1, stall1, valid1);
        end
    endtask

    task automatic test_invalid_sel();
        load = 0; ready = 1;
        cycle();
        sel = 2'd3; load = 1;
        cycle();
        total++;
        if (err1 !== 1'b1 || valid1 !== 1'b0) begin
            bad++;
            $display("FAIL invalid_sel: err=%b valid=%b want 1 0", err1, valid1);
        end
        sel = 2'd1; load = 1;
        cycle();
        total++;
        if (err1 !== 1'b1 || valid1 !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: err=%b valid=%b want 1 1", err1, valid1);
        end
    endtask

    task automatic test_async_reset();
        load = 0; ready = 0;
        repeat (3) cycle();
        #3;
        resetb = 1'b0;
        #1;
        model_clear();
        total++;
        if (state1 !== '0 || valid1 !== 1'b0 || err1 !== 1'b0 || stall1 !== 16'd0) begin
            bad++;
            $display("FAIL async_reset: state=%h valid=%b err=%b stall=%0d",
                     state1, valid1, err1, stall1);
        end
        @(posedge clk);
        #1;
        resetb = 1'b1;
        rand_inputs();
        sel = 2'd2; load = 1; ready = 1;
        cycle();
        total++;
        if (state1 !== cap(1) || valid1 !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_load: got %h want %h", state1, cap(1));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle();
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_plain_select();
        test_injection();
        test_back_pressure();
        test_invalid_sel();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
